// File: rtl/mvb_serializer_if.sv
// Handshake and serial-line bundle shared by the telegram builder, the MVB
// serializer and the line encoder.
interface mvb_serializer_if;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        serializer_wait;
  logic        data_out;
  logic        tx_active;
  logic        word_done;

  modport master (
    output data_in, data_valid, serializer_wait,
    input  data_ready, data_out, tx_active, word_done
  );

  modport slave (
    input  data_in, data_valid, serializer_wait,
    output data_ready, data_out, tx_active, word_done
  );
endinterface

// File: rtl/mvb_serializer.sv
// 16-bit parallel-to-serial transmitter for the 3 MHz MVB bit path, MSB first,
// with a one-word holding buffer. Define MVB_SER_PARITY_EN to append an even-parity bit.
module mvb_serializer #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic            clk_3M,
  input  logic            rst,
  mvb_serializer_if.slave bus
);

`ifdef MVB_SER_PARITY_EN
  localparam logic [4:0] LAST = 5'd16;
  localparam int         SHW  = 16;

  function automatic logic parity16(input logic [15:0] w);
    return ^w;
  endfunction
`else
  localparam logic [4:0] LAST = 5'd15;
  localparam int         SHW  = 15;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [SHW-1:0]   shreg_q, shreg_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             data_out_q, data_out_d;
  logic             tx_active_q, tx_active_d;
  logic             word_done_q, word_done_d;

  logic             data_ready_s;
  logic             accept_s;
  logic             load_s;
  logic             advance_s;

  assign data_ready_s   = rst & ~hold_full_q;
  assign bus.data_ready = data_ready_s;
  assign bus.data_out   = data_out_q;
  assign bus.tx_active  = tx_active_q;
  assign bus.word_done  = word_done_q;

  // State register.
  always_ff @(posedge clk_3M or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: pick between loading a word, shifting the next bit, or going idle.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    advance_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_full_q && !bus.serializer_wait) begin
          load_s  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (bus.serializer_wait) begin
          state_d = S_SHIFT;
        end else if (bit_cnt_q < LAST) begin
          advance_s = 1'b1;
        end else if (hold_full_q) begin
          // Reload straight from the holding buffer so no gap bit appears.
          load_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    accept_s    = bus.data_valid & data_ready_s;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    data_out_d  = data_out_q;
    word_done_d = 1'b0;
    tx_active_d = (state_d == S_SHIFT);

    if (load_s) begin
      data_out_d  = hold_q[15];
`ifdef MVB_SER_PARITY_EN
      shreg_d     = {hold_q[14:0], parity16(hold_q)};
`else
      shreg_d     = hold_q[14:0];
`endif
      bit_cnt_d   = 5'd0;
      hold_full_d = 1'b0;
    end else if (advance_s) begin
      data_out_d  = shreg_q[SHW-1];
      shreg_d     = {shreg_q[SHW-2:0], 1'b0};
      bit_cnt_d   = bit_cnt_q + 5'd1;
      word_done_d = (bit_cnt_d == LAST);
    end else if (state_d == S_IDLE) begin
      data_out_d  = IDLE_LEVEL;
    end else begin
      data_out_d  = data_out_q;
    end

    // Accept never coincides with a load: data_ready is low while hold is full.
    if (accept_s) begin
      hold_d      = bus.data_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end
  end

  // Datapath and registered line outputs.
  always_ff @(posedge clk_3M or negedge rst) begin
    if (!rst) begin
      hold_q      <= 16'd0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= 5'd0;
      data_out_q  <= IDLE_LEVEL;
      tx_active_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      data_out_q  <= data_out_d;
      tx_active_q <= tx_active_d;
      word_done_q <= word_done_d;
    end
  end

endmodule

// File: tb/tb_mvb_serializer.sv
// Self-checking bench for mvb_serializer: a queue-of-bits line model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mvb_serializer;
  localparam logic IDLE_LEVEL = 1'b0;
`ifdef MVB_SER_PARITY_EN
  localparam int          WBITS    = 17;
  localparam logic [16:0] A5C3_EXP = 17'h14B86;
`else
  localparam int          WBITS    = 16;
  localparam logic [16:0] A5C3_EXP = 17'h0A5C3;
`endif

  logic clk_3M = 1'b0;
  logic rst    = 1'b0;

  mvb_serializer_if bus();

  mvb_serializer #(.IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk_3M (clk_3M),
    .rst    (rst),
    .bus    (bus)
  );

  initial forever #5 clk_3M = ~clk_3M;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int act_cnt = 0;
  int wd_q[$];

  // Line model: a word becomes a queue of bits that drain one per unpaused cycle.
  bit          m_hold_full = 1'b0;
  logic [15:0] m_hold_word = 16'd0;
  bit          m_bits[$];
  bit          m_cur       = IDLE_LEVEL;
  bit          m_done      = 1'b0;
  bit          m_active    = 1'b0;

  function automatic bit model_ready();
    return (rst === 1'b1) && !m_hold_full;
  endfunction

  task automatic model_reset();
    m_hold_full = 1'b0;
    m_bits.delete();
    m_cur    = IDLE_LEVEL;
    m_done   = 1'b0;
    m_active = 1'b0;
  endtask

  task automatic model_load();
    for (int i = 15; i >= 0; i--) m_bits.push_back(m_hold_word[i]);
`ifdef MVB_SER_PARITY_EN
    m_bits.push_back(^m_hold_word);
`endif
    m_cur       = m_bits.pop_front();
    m_done      = 1'b0;
    m_active    = 1'b1;
    m_hold_full = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    acc = bus.data_valid && !m_hold_full;
    if (m_active) begin
      if (bus.serializer_wait) begin
        m_done = 1'b0;
      end else if (m_bits.size() > 0) begin
        m_cur  = m_bits.pop_front();
        m_done = (m_bits.size() == 0);
      end else if (m_hold_full) begin
        model_load();
      end else begin
        m_active = 1'b0;
        m_cur    = IDLE_LEVEL;
        m_done   = 1'b0;
      end
    end else if (m_hold_full && !bus.serializer_wait) begin
      model_load();
    end else begin
      m_cur  = IDLE_LEVEL;
      m_done = 1'b0;
    end
    if (acc) begin
      m_hold_full = 1'b1;
      m_hold_word = bus.data_in;
    end
  endtask

  initial forever begin
    @(posedge clk_3M or negedge rst);
    if (rst !== 1'b1) model_reset();
    else begin
      model_step();
      cyc++;
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk_3M);
    check1("data_out",   bus.data_out,   m_cur);
    check1("tx_active",  bus.tx_active,  m_active);
    check1("word_done",  bus.word_done,  m_done);
    check1("data_ready", bus.data_ready, model_ready());
    if (bus.tx_active === 1'b1) act_cnt++;
    if (bus.word_done === 1'b1) wd_q.push_back(cyc);
  end

  task automatic send(input logic [15:0] w);
    bit ok;
    bit done;
    done = 1'b0;
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      ok = model_ready();
      @(posedge clk_3M);
      #2;
      done = ok;
    end
    bus.data_valid = 1'b0;
    check1("send_accepted", done, 1'b1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 80 && !idle; i++) begin
      @(posedge clk_3M);
      #2;
      idle = !m_active && !m_hold_full;
    end
    check1("idle_reached", idle, 1'b1);
  endtask

  initial begin
    logic [16:0] stream;
    int          wd_hits;
    int          wd_pos;
    int          spacing;

    bus.data_in         = 16'd0;
    bus.data_valid      = 1'b0;
    bus.serializer_wait = 1'b0;

    // Reset held, then released with no stimulus.
    repeat (3) @(posedge clk_3M);
    #2;
    check1("reset_ready",    bus.data_ready, 1'b0);
    check1("reset_data_out", bus.data_out,   IDLE_LEVEL);
    rst = 1'b1;
    repeat (10) @(posedge clk_3M);
    #2;
    check1("idle_ready",     bus.data_ready, 1'b1);
    check1("idle_data_out",  bus.data_out,   1'b0);
    check1("idle_tx_active", bus.tx_active,  1'b0);
    check1("idle_word_done", bus.word_done,  1'b0);

    // Single word, captured bit by bit.
    send(16'hA5C3);
    stream  = 17'd0;
    wd_hits = 0;
    wd_pos  = -1;
    @(posedge clk_3M);
    for (int i = 0; i < WBITS; i++) begin
      @(negedge clk_3M);
      stream = {stream[15:0], bus.data_out};
      if (bus.word_done === 1'b1) begin
        wd_hits++;
        wd_pos = i;
      end
    end
    check_int("a5c3_stream",   int'(stream), int'(A5C3_EXP));
    check_int("a5c3_wd_hits",  wd_hits, 1);
    check_int("a5c3_wd_pos",   wd_pos,  WBITS - 1);
    @(negedge clk_3M);
    check1("a5c3_after_out",    bus.data_out,  1'b0);
    check1("a5c3_after_active", bus.tx_active, 1'b0);

    // Back-to-back words with the second accepted during the first.
    wd_q.delete();
    act_cnt = 0;
    send(16'hFFFF);
    send(16'h0001);
    wait_idle();
    spacing = (wd_q.size() >= 2) ? (wd_q[1] - wd_q[0]) : -1;
    check_int("b2b_pulses",  wd_q.size(), 2);
    check_int("b2b_spacing", spacing,     WBITS);
    check_int("b2b_active",  act_cnt,     2 * WBITS);

    // Pause for five cycles mid-word.
    act_cnt = 0;
    send(16'h8001);
    repeat (5) @(posedge clk_3M);
    #2;
    bus.serializer_wait = 1'b1;
    repeat (5) @(posedge clk_3M);
    #2;
    check1("wait_frozen_bit", bus.data_out, 1'b0);
    bus.serializer_wait = 1'b0;
    wait_idle();
    check_int("wait_tx_time", act_cnt, WBITS + 5);

    // Asynchronous reset mid-word with a second word waiting in hold.
    send(16'h1234);
    send(16'hBEEF);
    repeat (5) @(posedge clk_3M);
    #2;
    check1("pre_reset_bit", bus.data_out, 1'b1);
    rst = 1'b0;
    #1;
    check1("async_data_out",   bus.data_out,   IDLE_LEVEL);
    check1("async_data_ready", bus.data_ready, 1'b0);
    check1("async_tx_active",  bus.tx_active,  1'b0);
    @(posedge clk_3M);
    #2;
    rst     = 1'b1;
    act_cnt = 0;
    repeat (20) @(posedge clk_3M);
    #2;
    check_int("post_reset_active", act_cnt, 0);
    check1("post_reset_ready", bus.data_ready, 1'b1);

    // data_valid held high while a word shifts and hold is full.
    wd_q.delete();
    send(16'h3C3C);
    bus.data_in    = 16'h5555;
    bus.data_valid = 1'b1;
    #1;
    check1("held_ready_full", bus.data_ready, 1'b0);
    @(posedge clk_3M);
    #2;
    check1("held_ready_load", bus.data_ready, 1'b1);
    @(posedge clk_3M);
    #2;
    for (int i = 0; i < 8; i++) begin
      check1("held_ready_busy", bus.data_ready, 1'b0);
      @(posedge clk_3M);
      #1;
    end
    bus.data_valid = 1'b0;
    wait_idle();
    check_int("held_words", wd_q.size(), 2);

    repeat (3) @(posedge clk_3M);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mvb_serializer.md
Name: mvb_serializer

Overview:
- Parallel-to-serial transmitter for the 3 MHz MVB bit path; the transmit-side counterpart of the 16-bit deserializer.
- Accepts 16-bit words through a valid/ready handshake into a one-word holding buffer.
- Shifts each word out MSB first, one bit per clk_3M cycle. Holding a second word allows gap-free back-to-back transmission.
- Sits between the frame/telegram builder and the line encoder.

Parameters:
- IDLE_LEVEL, 1'b0, level driven on data_out when no word is being shifted.

Ports:
- clk_3M  input  1  3 MHz bit clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  16  parallel word to transmit.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  holding buffer is empty; word is accepted on an edge with data_valid && data_ready.
- serializer_wait  input  1  pause: freezes shifting while high.
- data_out  output  1  registered serial bit.
- tx_active  output  1  high while in SHIFT state.
- word_done  output  1  one-cycle pulse coincident with the last bit of a word on data_out.

Behaviour:
- Reset: rst low asynchronously forces the following, regardless of clock:
  - state=IDLE, hold_full=0, bit_cnt=0
  - data_out=IDLE_LEVEL, tx_active=0, word_done=0
  - data_ready is forced 0 while rst is low.
  - A word in flight when reset asserts is discarded; nothing resumes after release.
- Handshake:
  - data_ready = !hold_full (gated by rst).
  - Accept: hold<=data_in, hold_full<=1.
  - Accept and load cannot coincide, because data_ready is 0 whenever hold_full=1.
- IDLE state:
  - Load when hold_full && !serializer_wait. On the load edge:
    - data_out<=hold[15]; shreg<=hold[14:0]
    - hold_full<=0; bit_cnt<=0; tx_active<=1; state->SHIFT.
  - Otherwise data_out holds IDLE_LEVEL.
- SHIFT state:
  - If serializer_wait=1: data_out, shreg and bit_cnt are frozen; word_done=0. The bit position is retained, not restarted.
  - Else if bit_cnt<LAST: data_out<=shreg MSB, shreg shifts left, bit_cnt+1. word_done<=1 on the edge where bit_cnt+1==LAST.
  - Else (bit_cnt==LAST, the last bit's cycle has elapsed):
    - If hold_full: load next word exactly as in IDLE, so there is no gap bit.
    - Else: data_out<=IDLE_LEVEL, tx_active<=0, state->IDLE.
  - LAST=15 (16 bits per word).
- Timing:
  - Word accepted at edge N; load at edge N+1.
  - Bit15 on data_out during cycle N+1..N+2; bit0 during cycle N+16.
  - word_done is high during that bit0 cycle.
- Throughput: one word per 16 cycles, provided the next word is accepted before bit_cnt reaches LAST.
- Wrap-around: bit_cnt is a 5-bit counter, reset to 0 on every load; it never exceeds LAST.
- serializer_wait asserted exactly on a load edge blocks the load; the word stays in hold.

Optional Feature:
- Macro: MVB_SER_PARITY_EN.
- Defined:
  - LAST=16. After bit0, an extra bit equal to the XOR of all 16 data bits (even parity) is sent.
  - The parity is computed on load and stored.
  - word_done coincides with the parity bit.
  - Throughput is one word per 17 cycles.
- Undefined: no parity bit, LAST=15, and no parity register exists.

Test Plan:
- Reset release, no stimulus -> data_out=IDLE_LEVEL, data_ready=1, tx_active=0, word_done=0 indefinitely.
- Single word 16'hA5C3 -> serial stream 1010010111000011 over cycles N+1..N+16; word_done high only in cycle N+16; idle afterwards. With MVB_SER_PARITY_EN, bit 17 = 0 (popcount 8).
- Back-to-back 16'hFFFF then 16'h0001, second accepted during first word -> 32 contiguous bits, no idle gap; word_done pulses exactly 16 cycles apart.
- serializer_wait high for 5 cycles after bit 4 of 16'h8001 -> data_out holds bit 4 value for 6 cycles total; remaining bits unchanged; total transmit time 21 cycles.
- rst pulled low mid-word (bit 7 of 16'h1234), with a second word in hold -> data_out=IDLE_LEVEL immediately (before next edge); after release, no bits emitted until a new word is accepted.
- data_valid held high with 16'h5555 while a word is shifting and hold is full -> data_ready=0, no second acceptance until hold empties on the load edge.
